// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared constants and types for the MIPS32 pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch with single-outstanding imem handshake,
//            stall hold and branch/jump redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        instr_valid
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  pend_pc, pend_pc_nxt;
  logic         req_nxt;
  logic [31:0]  addr_nxt;
  logic [31:0]  pc_if_nxt;
  logic [31:0]  instr_if_nxt;
  logic         valid_nxt;
  logic [31:0]  target;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      pc_if       <= 32'h0;
      instr_if    <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_pc     <= pend_pc_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      pc_if       <= pc_if_nxt;
      instr_if    <= instr_if_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pc_nxt  = pend_pc;
    req_nxt      = 1'b0;
    addr_nxt     = imem_addr;
    pc_if_nxt    = pc_if;
    instr_if_nxt = instr_if;
    valid_nxt    = instr_valid;

    unique case (state)
      BOOT: begin
        req_nxt   = 1'b1;
        addr_nxt  = pc;
        state_nxt = WAIT;
      end

      WAIT: begin
        if (imem_rvalid && !redirect) begin
          pc_if_nxt    = pc;
          instr_if_nxt = imem_rdata;
          valid_nxt    = 1'b1;
          pc_nxt       = pc + PC_STEP;
          state_nxt    = HOLD;
        end else if (imem_rvalid) begin
          pc_nxt   = target;
          req_nxt  = 1'b1;
          addr_nxt = target;
        end else if (redirect) begin
          pend_pc_nxt = target;
          state_nxt   = DROP;
        end
      end

      DROP: begin
        // The stale response retires the old request; a same-cycle redirect wins over the saved target.
        if (imem_rvalid) begin
          pc_nxt    = redirect ? target : pend_pc;
          req_nxt   = 1'b1;
          addr_nxt  = redirect ? target : pend_pc;
          state_nxt = WAIT;
        end else if (redirect) begin
          pend_pc_nxt = target;
        end
      end

      HOLD: begin
        if (redirect || !stall) begin
          pc_if_nxt    = 32'h0;
          instr_if_nxt = NOP_INSTR;
          valid_nxt    = 1'b0;
          req_nxt      = 1'b1;
          state_nxt    = WAIT;
          pc_nxt       = redirect ? target : pc;
          addr_nxt     = redirect ? target : pc;
        end
      end

      default: state_nxt = BOOT;
    endcase
  end

endmodule

`default_nettype wire
